xorshift128plus_lanes: RTL

Parametrised multi-lane xorshift128+ pseudo-random source for the math library. LANES independent 128-bit generators step together, one step per cycle. Each output word is truncated to OUT_WIDTH bits per lane and buffered in a show-ahead FIFO of FIFO_DEPTH entries. Consumers (noise sources, dither, Monte-Carlo test benches) pop a word with a single-cycle read strobe.

---
 rtl/xorshift128plus_lanes.sv | 111 +++++++++++
 1 files changed

// File: rtl/xorshift128plus_lanes.sv
// Multi-lane xorshift128+ generator feeding a show-ahead output FIFO.
// All lanes step together, one step per cycle, whenever the FIFO can accept a word.
module xorshift128plus_lanes #(
    parameter int LANES      = 4,
    parameter int OUT_WIDTH  = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [128*LANES-1:0]          seed,
    input  logic                          seedStrobe,
    input  logic                          read,
    output logic                          randomReady,
    output logic [OUT_WIDTH*LANES-1:0]    randomValue,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int WORD_W = OUT_WIDTH * LANES;
    localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(FIFO_DEPTH);

    logic                seeded_reg;
    logic [PTR_W-1:0]    wr_ptr_reg;
    logic [PTR_W-1:0]    rd_ptr_reg;
    logic [LVL_W-1:0]    level_reg;
    logic [WORD_W-1:0]   fifo_mem [FIFO_DEPTH];
    logic [WORD_W-1:0]   push_word;
    logic                not_empty;
    logic                pop;
    logic                step;

    assign not_empty = (level_reg != '0);
    // A seed load flushes the FIFO, so a coincident read is simply dropped.
    assign pop  = read & not_empty & ~seedStrobe;
    assign step = seeded_reg & ~seedStrobe & ((level_reg != DEPTH_LVL) | pop);

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [63:0]  s0_reg;
            logic [63:0]  s1_reg;
            logic [63:0]  a_mix;
            logic [63:0]  s1_next;
            logic [63:0]  sum;
            logic [127:0] seed_slice;

            assign seed_slice = seed[128*gi +: 128];
            assign a_mix      = s0_reg ^ (s0_reg << 23);
            assign s1_next    = a_mix ^ s1_reg ^ (a_mix >> 17) ^ (s1_reg >> 26);
            assign sum        = s1_next + s1_reg;
            assign push_word[OUT_WIDTH*gi +: OUT_WIDTH] = sum[OUT_WIDTH-1:0];

            always_ff @(posedge clk) begin
                if (!rst) begin
                    s0_reg <= 64'd1;
                    s1_reg <= 64'd2;
                end else if (seedStrobe) begin
                    // An all-zero state would lock the generator at zero forever.
                    if (seed_slice == '0) begin
                        s0_reg <= 64'd1;
                        s1_reg <= 64'd2;
                    end else begin
                        s0_reg <= seed_slice[63:0];
                        s1_reg <= seed_slice[127:64];
                    end
                end else if (step) begin
                    s0_reg <= s1_reg;
                    s1_reg <= s1_next;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst && step) begin
            fifo_mem[wr_ptr_reg] <= push_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            seeded_reg <= 1'b0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else if (seedStrobe) begin
            seeded_reg <= 1'b1;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (step) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({step, pop})
                2'b10:   level_reg <= level_reg + LVL_W'(1);
                2'b01:   level_reg <= level_reg - LVL_W'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

    assign randomReady = not_empty;
    assign randomValue = not_empty ? fifo_mem[rd_ptr_reg] : '0;
    assign level       = level_reg;

endmodule
